reset_requester: RTL and testbench
==================================

RESET_REQUESTER -- requirements
Module: reset_requester

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1024, consecutive stable synchronized samples needed to accept a button level change.
REQ-002 Parameter HOLD_CYCLES, default 64, minimum cycles reset_request stays high per request.
REQ-003 Parameter SW_KEY, default 8'hA5, key value that qualifies a software reset write.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high; driven only by the power-on/PLL reset, never by reset_request.
REQ-006 button_n  input  1  asynchronous user reset button, active-low.
REQ-007 sw_write  input  1  single-cycle CPU write strobe.
REQ-008 sw_key  input  8  data accompanying sw_write.
REQ-009 reset_busy  input  1  high while the downstream reset generator holds system reset.
REQ-010 reset_request  output  1  active-high request to the reset generator.
REQ-011 cause  output  2  last request source: 00 none, 01 button, 10 software, 11 reserved.
REQ-012 request_count  output  8  saturating count of accepted requests.

Function
REQ-013 button_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples differing from it; any matching sample restarts the count.
REQ-015 Button event SHALL be the debounced pressed edge (debounced level going low); it is a one-cycle internal pulse.
REQ-016 Software event SHALL be sw_write high with sw_key == SW_KEY in the same cycle; other keys are ignored with no side effect.
REQ-017 FSM states: IDLE, REQUEST, WAIT_RELEASE.
REQ-018 IDLE: on an event, go to REQUEST next edge, load hold counter with HOLD_CYCLES-1, set cause, increment request_count.
REQ-019 reset_request SHALL be high exactly in REQUEST and WAIT_RELEASE; first high cycle is the cycle after the event (latency 1).
REQ-020 REQUEST: decrement hold counter; at zero go to WAIT_RELEASE; reset_request high for at least HOLD_CYCLES cycles.
REQ-021 WAIT_RELEASE: return to IDLE when reset_busy is low AND debounced button is released; reset_request falls the same edge.
REQ-022 Button and software events in the same cycle SHALL be accepted as one request with cause=01.
REQ-023 Events in REQUEST or WAIT_RELEASE SHALL be ignored: no cause change, no count change.
REQ-024 request_count SHALL saturate at 8'hFF and not wrap.
REQ-025 cause SHALL hold its value after returning to IDLE until the next accepted request or reset.
REQ-026 Hold counter width SHALL be $clog2(HOLD_CYCLES+1); debounce counter width $clog2(DEBOUNCE_CYCLES+1).

Reset
REQ-027 On reset: state IDLE, reset_request 0, cause 00, request_count 0, counters 0.
REQ-028 Synchronizer flops and debounced level SHALL reset to released (1), so a button held through reset produces no event until released and re-pressed.
REQ-029 Reset asserted mid-REQUEST or mid-WAIT_RELEASE SHALL drop reset_request on the same edge and discard the pending request.

Structure
REQ-030 Cause encodings and SW_KEY default SHALL live in the shared system package used by the reset generator and CPU register map.
REQ-031 Debouncer SHALL be a sub-module named button_debouncer (synchronizer, counter, debounced level, pressed-edge pulse); FSM stays in reset_requester.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=3)
REQ-032 button_n low held 10 cycles, reset_busy 0 -> reset_request high 1 cycle after debounced edge, stays high until button released and debounced; cause=01, count=1.
REQ-033 button_n glitch low for 3 cycles -> no request, count=0.
REQ-034 sw_write with sw_key=8'hA5, reset_busy high for 8 cycles -> reset_request high from next cycle through the cycle reset_busy falls, >=3 cycles; cause=10. Same with 8'h5A -> nothing.
REQ-035 Button event and valid sw_write same cycle -> one request, cause=01, count=1; second sw_write during REQUEST -> count stays 1.
REQ-036 Reset pulsed 2 cycles into REQUEST -> reset_request 0 at that edge, cause=00, count=0; button held through reset -> no new request until release and re-press.
REQ-037 Preload 255 accepted requests -> 256th accepted, request_count stays 8'hFF.

Source files
------------

// File: rtl/reset_requester_pkg.sv
// Shared system definitions for the reset requester, reset generator and CPU register map:
// request cause encodings, software reset key and the requester FSM states.
package reset_requester_pkg;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_BUTTON   = 2'b01,
      CAUSE_SOFTWARE = 2'b10,
      CAUSE_RESERVED = 2'b11
   } cause_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_WAIT_RELEASE
   } req_state_e;

   localparam logic [7:0] SW_KEY_DEFAULT = 8'hA5;
   localparam logic [7:0] COUNT_MAX      = 8'hFF;

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == COUNT_MAX) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/reset_requester_button_debouncer.sv
// Button conditioning: 2-flop synchronizer, debounce counter, debounced level and a
// one-cycle pulse on the debounced pressed edge.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic button_n,
   output logic level,
   output logic pressed
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [1:0]    fill;
   logic          armed;
   logic [CW-1:0] count;

   // fill marks when sync2 first carries a real button sample rather than its reset value;
   // armed stays low until a released sample is seen, so a button held through reset
   // cannot produce a pressed edge until it is released and pressed again.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         fill    <= 2'b00;
         armed   <= 1'b0;
         count   <= '0;
         level   <= 1'b1;
         pressed <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep sync1 -> sync2 a true two-stage shift.
         sync1   <= button_n;
         sync2   <= sync1;
         fill    <= {fill[0], 1'b1};
         pressed <= 1'b0;
         if (fill[1] && sync2 && level)
            armed <= 1'b1;
         if (sync2 == level) begin
            count <= '0;
         end else if (count == LAST) begin
            level   <= sync2;
            count   <= '0;
            pressed <= armed & ~sync2;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/reset_requester.sv
// Reset request controller: turns debounced button presses and keyed software writes
// into a held reset_request, recording the cause and a saturating request count.
module reset_requester
   import reset_requester_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1024,
   parameter int unsigned HOLD_CYCLES     = 64,
   parameter logic [7:0]  SW_KEY          = SW_KEY_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       button_n,
   input  logic       sw_write,
   input  logic [7:0] sw_key,
   input  logic       reset_busy,
   output logic       reset_request,
   output logic [1:0] cause,
   output logic [7:0] request_count
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   req_state_e    state;
   cause_e        cause_q;
   logic [HW-1:0] hold_count;
   logic          button_level;
   logic          button_event;
   logic          sw_event;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk      (clk),
      .reset    (reset),
      .button_n (button_n),
      .level    (button_level),
      .pressed  (button_event)
   );

   assign sw_event = sw_write && (sw_key == SW_KEY);
   assign cause    = cause_q;

   // Events outside IDLE fall through untouched, so cause and count only move on acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         reset_request <= 1'b0;
         cause_q       <= CAUSE_NONE;
         request_count <= '0;
         hold_count    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (button_event || sw_event) begin
                  state         <= ST_REQUEST;
                  reset_request <= 1'b1;
                  hold_count    <= HOLD_LOAD;
                  cause_q       <= button_event ? CAUSE_BUTTON : CAUSE_SOFTWARE;
                  request_count <= sat_inc(request_count);
               end
            end
            ST_REQUEST: begin
               if (hold_count == '0)
                  state <= ST_WAIT_RELEASE;
               else
                  hold_count <= hold_count - 1'b1;
            end
            ST_WAIT_RELEASE: begin
               if (!reset_busy && button_level) begin
                  state         <= ST_IDLE;
                  reset_request <= 1'b0;
               end
            end
            default: begin
               state         <= ST_IDLE;
               reset_request <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_requester.sv
// Scoreboard bench for reset_requester (DEBOUNCE_CYCLES=4, HOLD_CYCLES=3): stimulus pushes
// expected requests, a monitor pops and compares each time reset_request rises.
module tb_reset_requester;

   localparam int unsigned DEB  = 4;
   localparam int unsigned HOLD = 3;

   typedef struct {
      logic [1:0] cause;
      logic [7:0] count;
      int         min_len;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       button_n = 1'b1;
   logic       sw_write = 1'b0;
   logic [7:0] sw_key = 8'h00;
   logic       reset_busy = 1'b0;
   logic       reset_request;
   logic [1:0] cause;
   logic [7:0] request_count;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   reset_requester #(
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD),
      .SW_KEY          (8'hA5)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .button_n      (button_n),
      .sw_write      (sw_write),
      .sw_key        (sw_key),
      .reset_busy    (reset_busy),
      .reset_request (reset_request),
      .cause         (cause),
      .request_count (request_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic push(input logic [1:0] c, input logic [7:0] n, input int min_len);
      exp_t e;
      e.cause   = c;
      e.count   = n;
      e.min_len = min_len;
      exp_q.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_low(input int max_cycles, input string name);
      int n = 0;
      while (reset_request !== 1'b0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      if (reset_request !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL %s: reset_request still %0b after %0d cycles", name, reset_request, max_cycles);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      cycles(n);
      reset = 1'b0;
      cycles(5);
   endtask

   task automatic sw_pulse(input logic [7:0] key);
      sw_write = 1'b1;
      sw_key   = key;
      @(negedge clk);
      sw_write = 1'b0;
      sw_key   = 8'h00;
   endtask

   // Monitor: pop an expectation on each rising reset_request, check length on the fall.
   initial begin : monitor
      logic prev_req;
      exp_t cur;
      int   len;
      prev_req = 1'b0;
      len      = 0;
      cur.cause = 2'b00; cur.count = 8'h00; cur.min_len = 0;
      forever begin
         @(negedge clk);
         if (reset_request === 1'b1 && prev_req === 1'b0) begin
            len = 1;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_request: cause=%0h count=%0h with no request expected at %0t",
                        cause, request_count, $time);
               cur.cause = cause; cur.count = request_count; cur.min_len = 0;
            end else begin
               cur = exp_q.pop_front();
               check("mon_cause", 32'(cause), 32'(cur.cause));
               check("mon_count", 32'(request_count), 32'(cur.count));
            end
         end else if (reset_request === 1'b1) begin
            len++;
         end else if (prev_req === 1'b1 && cur.min_len > 0) begin
            check("mon_len_ge_hold", 32'(len >= cur.min_len), 32'd1);
         end
         prev_req = reset_request;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      cycles(2);
      check("rst_request", 32'(reset_request), 32'd0);
      check("rst_cause", 32'(cause), 32'd0);
      check("rst_count", 32'(request_count), 32'd0);
      reset = 1'b0;
      cycles(5);

      // Button held 10 cycles: 2 sync + 4 debounce + pulse, request on the 7th edge.
      push(2'b01, 8'd1, HOLD);
      button_n = 1'b0;
      cycles(6);
      check("btn_not_yet", 32'(reset_request), 32'd0);
      cycles(1);
      check("btn_latency", 32'(reset_request), 32'd1);
      cycles(3);
      button_n = 1'b1;
      cycles(5);
      check("btn_held_until_release", 32'(reset_request), 32'd1);
      wait_low(10, "btn_release");
      check("btn_cause", 32'(cause), 32'd1);
      check("btn_count", 32'(request_count), 32'd1);

      // Three-cycle glitch must not pass the debouncer.
      cycles(3);
      button_n = 1'b0;
      cycles(3);
      button_n = 1'b1;
      cycles(15);
      check("glitch_request", 32'(reset_request), 32'd0);
      check("glitch_count", 32'(request_count), 32'd1);

      // Keyed software write with reset_busy high for 8 cycles.
      push(2'b10, 8'd2, HOLD);
      reset_busy = 1'b1;
      sw_pulse(8'hA5);
      check("sw_latency", 32'(reset_request), 32'd1);
      cycles(7);
      check("sw_high_while_busy", 32'(reset_request), 32'd1);
      reset_busy = 1'b0;
      cycles(1);
      check("sw_falls_after_busy", 32'(reset_request), 32'd0);
      check("sw_cause", 32'(cause), 32'd2);
      check("sw_count", 32'(request_count), 32'd2);

      // Wrong key: no side effect.
      sw_pulse(8'h5A);
      cycles(5);
      check("badkey_request", 32'(reset_request), 32'd0);
      check("badkey_cause", 32'(cause), 32'd2);
      check("badkey_count", 32'(request_count), 32'd2);

      // Button pulse and valid write in the same cycle; second write during REQUEST ignored.
      do_reset(2);
      push(2'b01, 8'd1, HOLD);
      button_n = 1'b0;
      cycles(6);
      sw_pulse(8'hA5);
      check("both_request", 32'(reset_request), 32'd1);
      sw_pulse(8'hA5);
      cycles(3);
      button_n = 1'b1;
      wait_low(20, "both_release");
      check("both_cause", 32'(cause), 32'd1);
      check("both_count", 32'(request_count), 32'd1);

      // Reset pulsed two cycles into REQUEST with the button held throughout.
      do_reset(2);
      push(2'b01, 8'd1, 0);
      button_n = 1'b0;
      cycles(7);
      check("abort_request_up", 32'(reset_request), 32'd1);
      cycles(1);
      reset = 1'b1;
      cycles(1);
      check("abort_request", 32'(reset_request), 32'd0);
      check("abort_cause", 32'(cause), 32'd0);
      check("abort_count", 32'(request_count), 32'd0);
      reset = 1'b0;
      cycles(20);
      check("held_no_request", 32'(reset_request), 32'd0);
      check("held_count", 32'(request_count), 32'd0);
      button_n = 1'b1;
      cycles(12);
      push(2'b01, 8'd1, HOLD);
      button_n = 1'b0;
      cycles(10);
      button_n = 1'b1;
      wait_low(20, "repress_release");
      check("repress_count", 32'(request_count), 32'd1);

      // 256 software requests: the count saturates at FF.
      do_reset(2);
      for (int i = 1; i <= 256; i++) begin
         push(2'b10, (i > 255) ? 8'hFF : 8'(i), HOLD);
         sw_pulse(8'hA5);
         wait_low(20, "sat_release");
      end
      cycles(2);
      check("sat_count", 32'(request_count), 32'hFF);
      check("sat_cause", 32'(cause), 32'd2);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
